// File: rtl/sci_master.sv
// =============================================================================
// Module   : sci_master
// Purpose  : Serial control interface master. Accepts a read/write command,
//            selects one peripheral via an active-low chip select, shifts the
//            write flag, address and (for writes) data out LSB first on
//            sci_req, waits for the slave acknowledge and, for reads, shifts
//            the read data in LSB first from sci_resp. Each command ends with
//            a one-cycle response pulse and a one-cycle release gap.
// Ports    : clk, rstn        - clock, synchronous active-low reset
//            i_cmd_*          - command request (valid/write/pid/addr/wdata)
//            o_cmd_ready      - high only while idle
//            o_rsp_*          - completion pulse, read data, error flag
//            o_sci_csn        - registered active-low chip selects
//            o_sci_req        - registered serial request line
//            i_sci_resp       - serial response line from the slave
//            i_sci_ack        - slave acknowledge
// Revision : 1.0 - initial release
// =============================================================================
`default_nettype none

module sci_master #(
  parameter int  NUM_PERIPHERALS = 1,
  parameter int  ADDR_WIDTH      = 4,
  parameter int  DATA_WIDTH      = 8,
  parameter int  ACK_TIMEOUT     = 64,
  localparam int PID_WIDTH       = (NUM_PERIPHERALS > 1) ? $clog2(NUM_PERIPHERALS) : 1
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       i_cmd_valid,
  output logic                       o_cmd_ready,
  input  logic                       i_cmd_write,
  input  logic [PID_WIDTH-1:0]       i_cmd_pid,
  input  logic [ADDR_WIDTH-1:0]      i_cmd_addr,
  input  logic [DATA_WIDTH-1:0]      i_cmd_wdata,
  output logic                       o_rsp_valid,
  output logic [DATA_WIDTH-1:0]      o_rsp_rdata,
  output logic                       o_rsp_error,
  output logic [NUM_PERIPHERALS-1:0] o_sci_csn,
  output logic                       o_sci_req,
  input  logic                       i_sci_resp,
  input  logic                       i_sci_ack
);

  // ---------------------------------------------------------------------------
  // Constants
  // ---------------------------------------------------------------------------
  localparam int c_MAX_W  = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
  localparam int c_BCNT_W = (c_MAX_W > 1) ? $clog2(c_MAX_W) : 1;
  localparam int c_WCNT_W = (ACK_TIMEOUT > 0) ? $clog2(ACK_TIMEOUT + 1) : 1;

  localparam logic [c_BCNT_W-1:0] c_ADDR_LAST = c_BCNT_W'(ADDR_WIDTH - 1);
  localparam logic [c_BCNT_W-1:0] c_DATA_LAST = c_BCNT_W'(DATA_WIDTH - 1);
  localparam logic [c_BCNT_W-1:0] c_BCNT_ONE  = c_BCNT_W'(1);
  // Counter value on the last permitted wait edge; the abort happens on the
  // edge that would otherwise carry the count up to ACK_TIMEOUT.
  localparam logic [c_WCNT_W-1:0] c_WAIT_LAST =
    (ACK_TIMEOUT > 0) ? c_WCNT_W'(ACK_TIMEOUT - 1) : '0;
  localparam logic                c_TIMEOUT_EN = (ACK_TIMEOUT > 0);

  localparam logic [2:0] c_S_IDLE     = 3'd0;
  localparam logic [2:0] c_S_ADDR     = 3'd1;
  localparam logic [2:0] c_S_WDATA    = 3'd2;
  localparam logic [2:0] c_S_WAIT_ACK = 3'd3;
  localparam logic [2:0] c_S_RDATA    = 3'd4;
  localparam logic [2:0] c_S_RELEASE  = 3'd5;

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  logic [2:0]                 r_state;
  logic [NUM_PERIPHERALS-1:0] r_csn;
  logic                       r_req;
  logic                       r_rsp_valid;
  logic                       r_rsp_error;
  logic [DATA_WIDTH-1:0]      r_rsp_rdata;
  logic                       r_write;
  logic [ADDR_WIDTH-1:0]      r_addr_sh;
  logic [DATA_WIDTH-1:0]      r_wdata_sh;
  logic [DATA_WIDTH-1:0]      r_rx;
  logic [c_BCNT_W-1:0]        r_bit_cnt;
  logic [c_WCNT_W-1:0]        r_wait_cnt;

  // ---------------------------------------------------------------------------
  // Combinational next values
  // ---------------------------------------------------------------------------
  logic [2:0]                 w_state_nxt;
  logic [NUM_PERIPHERALS-1:0] w_csn_nxt;
  logic                       w_req_nxt;
  logic                       w_rsp_valid_nxt;
  logic                       w_rsp_error_nxt;
  logic [DATA_WIDTH-1:0]      w_rsp_rdata_nxt;
  logic                       w_write_nxt;
  logic [ADDR_WIDTH-1:0]      w_addr_sh_nxt;
  logic [DATA_WIDTH-1:0]      w_wdata_sh_nxt;
  logic [DATA_WIDTH-1:0]      w_rx_nxt;
  logic [c_BCNT_W-1:0]        w_bit_cnt_nxt;
  logic [c_WCNT_W-1:0]        w_wait_cnt_nxt;

  logic                       w_pid_ok;
  logic [NUM_PERIPHERALS-1:0] w_csn_sel;
  logic                       w_addr_last;
  logic                       w_data_last;
  logic                       w_timeout;
  logic [DATA_WIDTH-1:0]      w_rx_shift;

  assign w_pid_ok    = (32'(i_cmd_pid) < 32'(NUM_PERIPHERALS));
  assign w_addr_last = (r_bit_cnt == c_ADDR_LAST);
  assign w_data_last = (r_bit_cnt == c_DATA_LAST);
  assign w_timeout   = c_TIMEOUT_EN && (r_wait_cnt == c_WAIT_LAST);

  // Chip-select pattern for the requested peripheral: only bit cmd_pid low.
  always_comb begin
    w_csn_sel = '1;
    for (int i = 0; i < NUM_PERIPHERALS; i++) begin
      w_csn_sel[i] = (i_cmd_pid != PID_WIDTH'(i));
    end
  end

  // Read data arrives LSB first, so new bits enter at the MSB and the word
  // shifts right; after DATA_WIDTH beats the first bit sits at bit 0.
  always_comb begin
    w_rx_shift                 = r_rx >> 1;
    w_rx_shift[DATA_WIDTH-1]   = i_sci_resp;
  end

  // ---------------------------------------------------------------------------
  // FSM process 1: state and datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state     <= c_S_IDLE;
      r_csn       <= '1;
      r_req       <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_error <= 1'b0;
      r_rsp_rdata <= '0;
      r_write     <= 1'b0;
      r_addr_sh   <= '0;
      r_wdata_sh  <= '0;
      r_rx        <= '0;
      r_bit_cnt   <= '0;
      r_wait_cnt  <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_csn       <= w_csn_nxt;
      r_req       <= w_req_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_rsp_error <= w_rsp_error_nxt;
      r_rsp_rdata <= w_rsp_rdata_nxt;
      r_write     <= w_write_nxt;
      r_addr_sh   <= w_addr_sh_nxt;
      r_wdata_sh  <= w_wdata_sh_nxt;
      r_rx        <= w_rx_nxt;
      r_bit_cnt   <= w_bit_cnt_nxt;
      r_wait_cnt  <= w_wait_cnt_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM process 2: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_S_IDLE: begin
        if (i_cmd_valid) begin
          // An out-of-range pid still passes through RELEASE so every
          // command sees the same response/gap shape.
          w_state_nxt = w_pid_ok ? c_S_ADDR : c_S_RELEASE;
        end
      end
      c_S_ADDR: begin
        if (w_addr_last) begin
          w_state_nxt = r_write ? c_S_WDATA : c_S_WAIT_ACK;
        end
      end
      c_S_WDATA: begin
        if (w_data_last) begin
          w_state_nxt = c_S_WAIT_ACK;
        end
      end
      c_S_WAIT_ACK: begin
        // Ack takes priority over the timeout on the final wait edge.
        if (i_sci_ack) begin
          w_state_nxt = (r_write || (DATA_WIDTH == 1)) ? c_S_RELEASE : c_S_RDATA;
        end else if (w_timeout) begin
          w_state_nxt = c_S_RELEASE;
        end
      end
      c_S_RDATA: begin
        if (!i_sci_ack || w_data_last) begin
          w_state_nxt = c_S_RELEASE;
        end
      end
      c_S_RELEASE: begin
        w_state_nxt = c_S_IDLE;
      end
      default: begin
        w_state_nxt = c_S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM process 3: output and datapath next values
  // ---------------------------------------------------------------------------
  // sci_req and the response outputs default to 0 every cycle, so the line is
  // quiet outside the shift phases and rsp_valid is a single-cycle pulse.
  always_comb begin
    w_csn_nxt       = r_csn;
    w_req_nxt       = 1'b0;
    w_rsp_valid_nxt = 1'b0;
    w_rsp_error_nxt = 1'b0;
    w_rsp_rdata_nxt = '0;
    w_write_nxt     = r_write;
    w_addr_sh_nxt   = r_addr_sh;
    w_wdata_sh_nxt  = r_wdata_sh;
    w_rx_nxt        = r_rx;
    w_bit_cnt_nxt   = r_bit_cnt;
    w_wait_cnt_nxt  = r_wait_cnt;

    case (r_state)
      c_S_IDLE: begin
        w_csn_nxt = '1;
        if (i_cmd_valid) begin
          w_write_nxt    = i_cmd_write;
          w_addr_sh_nxt  = i_cmd_addr;
          w_wdata_sh_nxt = i_cmd_wdata;
          w_rx_nxt       = '0;
          w_bit_cnt_nxt  = '0;
          w_wait_cnt_nxt = '0;
          if (w_pid_ok) begin
            w_csn_nxt = w_csn_sel;
            // The write flag is the first bit on the line.
            w_req_nxt = i_cmd_write;
          end else begin
            w_rsp_valid_nxt = 1'b1;
            w_rsp_error_nxt = 1'b1;
          end
        end
      end

      c_S_ADDR: begin
        w_req_nxt     = r_addr_sh[0];
        w_addr_sh_nxt = r_addr_sh >> 1;
        w_bit_cnt_nxt = w_addr_last ? '0 : r_bit_cnt + 1'b1;
      end

      c_S_WDATA: begin
        w_req_nxt      = r_wdata_sh[0];
        w_wdata_sh_nxt = r_wdata_sh >> 1;
        w_bit_cnt_nxt  = w_data_last ? '0 : r_bit_cnt + 1'b1;
      end

      c_S_WAIT_ACK: begin
        if (i_sci_ack) begin
          if (r_write) begin
            w_csn_nxt       = '1;
            w_rsp_valid_nxt = 1'b1;
          end else if (DATA_WIDTH == 1) begin
            w_csn_nxt       = '1;
            w_rsp_valid_nxt = 1'b1;
            w_rsp_rdata_nxt = w_rx_shift;
          end else begin
            // The ack edge also carries read bit 0.
            w_rx_nxt      = w_rx_shift;
            w_bit_cnt_nxt = c_BCNT_ONE;
          end
        end else begin
          w_wait_cnt_nxt = r_wait_cnt + 1'b1;
          if (w_timeout) begin
            w_csn_nxt       = '1;
            w_rsp_valid_nxt = 1'b1;
            w_rsp_error_nxt = 1'b1;
          end
        end
      end

      c_S_RDATA: begin
        if (i_sci_ack) begin
          w_rx_nxt      = w_rx_shift;
          w_bit_cnt_nxt = r_bit_cnt + 1'b1;
          if (w_data_last) begin
            w_csn_nxt       = '1;
            w_rsp_valid_nxt = 1'b1;
            w_rsp_rdata_nxt = w_rx_shift;
          end
        end else begin
          // Lost ack mid-burst: partial data is discarded.
          w_csn_nxt       = '1;
          w_rsp_valid_nxt = 1'b1;
          w_rsp_error_nxt = 1'b1;
        end
      end

      c_S_RELEASE: begin
        w_csn_nxt = '1;
      end

      default: begin
        w_csn_nxt = '1;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign o_cmd_ready = (r_state == c_S_IDLE);
  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_error = r_rsp_error;
  assign o_rsp_rdata = r_rsp_rdata;
  assign o_sci_csn   = r_csn;
  assign o_sci_req   = r_req;

endmodule

`default_nettype wire

// File: tb/tb_sci_master.sv
// =============================================================================
// Module   : tb_sci_master
// Purpose  : Self-checking bench for sci_master. A table of transactions is
//            played against a 4-peripheral instance with a scripted slave;
//            expected responses go through a scoreboard queue. A 3-peripheral
//            instance covers the out-of-range pid case.
// Revision : 1.0 - initial release
// =============================================================================
`default_nettype none

module tb_sci_master;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- 4-peripheral instance (A=4, D=8, timeout 16) ------------
  logic       c4_valid = 0, c4_write = 0;
  logic [1:0] c4_pid = 0;
  logic [3:0] c4_addr = 0;
  logic [7:0] c4_wdata = 0;
  logic       ack4 = 0, resp4 = 0;
  logic       o4_cmd_ready, o4_rsp_valid, o4_rsp_error, o4_sci_req;
  logic [7:0] o4_rsp_rdata;
  logic [3:0] o4_sci_csn;

  sci_master #(.NUM_PERIPHERALS(4), .ADDR_WIDTH(4), .DATA_WIDTH(8), .ACK_TIMEOUT(16)) u_dut4 (
    .clk(clk), .rstn(rstn),
    .i_cmd_valid(c4_valid), .o_cmd_ready(o4_cmd_ready), .i_cmd_write(c4_write),
    .i_cmd_pid(c4_pid), .i_cmd_addr(c4_addr), .i_cmd_wdata(c4_wdata),
    .o_rsp_valid(o4_rsp_valid), .o_rsp_rdata(o4_rsp_rdata), .o_rsp_error(o4_rsp_error),
    .o_sci_csn(o4_sci_csn), .o_sci_req(o4_sci_req),
    .i_sci_resp(resp4), .i_sci_ack(ack4)
  );

  // ---------------- 3-peripheral instance ------------------------------------
  logic       c3_valid = 0, c3_write = 0;
  logic [1:0] c3_pid = 0;
  logic [3:0] c3_addr = 0;
  logic [7:0] c3_wdata = 0;
  logic       ack3 = 0, resp3 = 0;
  logic       o3_cmd_ready, o3_rsp_valid, o3_rsp_error, o3_sci_req;
  logic [7:0] o3_rsp_rdata;
  logic [2:0] o3_sci_csn;

  sci_master #(.NUM_PERIPHERALS(3), .ADDR_WIDTH(4), .DATA_WIDTH(8), .ACK_TIMEOUT(64)) u_dut3 (
    .clk(clk), .rstn(rstn),
    .i_cmd_valid(c3_valid), .o_cmd_ready(o3_cmd_ready), .i_cmd_write(c3_write),
    .i_cmd_pid(c3_pid), .i_cmd_addr(c3_addr), .i_cmd_wdata(c3_wdata),
    .o_rsp_valid(o3_rsp_valid), .o_rsp_rdata(o3_rsp_rdata), .o_rsp_error(o3_rsp_error),
    .o_sci_csn(o3_sci_csn), .o_sci_req(o3_sci_req),
    .i_sci_resp(resp3), .i_sci_ack(ack3)
  );

  // ---------------- Check helper ----------------------------------------------
  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s [%0d]: got 0x%0h, expected 0x%0h", name, idx, act, exp);
    end
  endtask

  // ---------------- Scoreboard ------------------------------------------------
  typedef struct packed {
    logic       err;
    logic [7:0] rdata;
  } rsp_t;

  rsp_t sb_q[$];

  always @(negedge clk) begin
    if (o4_rsp_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL rsp_unexpected: got rsp_valid=1 err=%0b rdata=0x%0h, expected no response",
                 o4_rsp_error, o4_rsp_rdata);
      end else begin
        rsp_t e;
        e = sb_q.pop_front();
        check("rsp_error", -1, 32'(o4_rsp_error), 32'(e.err));
        check("rsp_rdata", -1, 32'(o4_rsp_rdata), 32'(e.rdata));
      end
    end
  end

  // ---------------- Transaction table ----------------------------------------
  typedef struct {
    bit       write;
    bit [1:0] pid;
    bit [3:0] addr;
    bit [7:0] wdata;
    int       ack_delay;  // wait edges before ack; -1 = slave never acks
    bit       ack_early;  // drive ack/resp high during the header phase
    bit [7:0] rdata;      // slave read data, sent LSB first
    int       drop_beat;  // read beat where ack drops; -1 = none
    bit [3:0] exp_csn;
    bit       exp_err;
    bit [7:0] exp_rdata;
  } vec_t;

  vec_t vecs[10];

  // Plays one transaction on u_dut4, scripting the slave edge by edge.
  // Sample n is taken on the negedge after edge n-1 (edge 0 = accept edge).
  task automatic run_vec(input vec_t v, input int idx);
    int          hdr, rsp_edge, rsp_at, done_at, w, j;
    logic [12:0] seq;
    hdr = v.write ? 13 : 5;
    seq = {v.wdata, v.addr, v.write};
    if (v.ack_delay < 0 || v.ack_delay >= 16) rsp_edge = hdr + 15;
    else if (v.write)                         rsp_edge = hdr + v.ack_delay;
    else if (v.drop_beat >= 0)                rsp_edge = hdr + v.ack_delay + v.drop_beat;
    else                                      rsp_edge = hdr + v.ack_delay + 7;
    rsp_at  = -1;
    done_at = -1;

    @(negedge clk);
    check("cmd_ready_idle", idx, 32'(o4_cmd_ready), 32'(1));
    c4_valid = 1; c4_write = v.write; c4_pid = v.pid; c4_addr = v.addr; c4_wdata = v.wdata;
    ack4 = v.ack_early; resp4 = v.ack_early;
    sb_q.push_back({v.exp_err, v.exp_rdata});

    for (int n = 1; n <= 120; n++) begin
      @(negedge clk);
      c4_valid = 0;
      if (n == 1) begin
        check("csn_select", idx, 32'(o4_sci_csn), 32'(v.exp_csn));
        check("cmd_ready_busy", idx, 32'(o4_cmd_ready), 32'(0));
      end
      if (n - 1 < hdr) check("sci_req_bit", idx * 100 + n - 1, 32'(o4_sci_req), 32'(seq[n-1]));
      if (o4_rsp_valid && rsp_at < 0) rsp_at = n - 1;
      if (n - 1 == rsp_edge) begin
        check("csn_release", idx, 32'(o4_sci_csn), 32'(4'hF));
        check("req_release", idx, 32'(o4_sci_req), 32'(0));
      end
      if (n > 1 && o4_cmd_ready) begin
        done_at = n - 1;
        break;
      end
      // Slave script for edge n.
      w = n - hdr;
      ack4 = 0; resp4 = 0;
      if (w < 0) begin
        ack4 = v.ack_early; resp4 = v.ack_early;
      end else if (v.ack_delay >= 0 && w >= v.ack_delay) begin
        j = w - v.ack_delay;
        if (v.write) ack4 = (j == 0);
        else if (j < 8) begin
          ack4  = (j != v.drop_beat);
          resp4 = v.rdata[j];
        end
      end
    end
    check("rsp_edge", idx, 32'(rsp_at), 32'(rsp_edge));
    check("ready_edge", idx, 32'(done_at), 32'(rsp_edge + 1));
    ack4 = 0; resp4 = 0;
  endtask

  // ---------------- Watchdog ---------------------------------------------------
  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected completion within time limit");
    $fatal(1);
  end

  // ---------------- Main sequence ---------------------------------------------
  initial begin
    int cnt;
    bit got;
    //           wr  pid   addr   wdata  dly early rdata  drop csn      err rdata
    vecs[0] = '{1, 2'd2, 4'h5, 8'hA3,  2, 0, 8'h00, -1, 4'b1011, 0, 8'h00};
    vecs[1] = '{0, 2'd0, 4'hC, 8'h00,  0, 0, 8'h5A, -1, 4'b1110, 0, 8'h5A};
    vecs[2] = '{1, 2'd3, 4'hF, 8'h00,  0, 1, 8'h00, -1, 4'b0111, 0, 8'h00};
    vecs[3] = '{0, 2'd1, 4'h3, 8'h00,  5, 0, 8'hC3, -1, 4'b1101, 0, 8'hC3};
    vecs[4] = '{1, 2'd0, 4'h7, 8'h55, -1, 0, 8'h00, -1, 4'b1110, 1, 8'h00};
    vecs[5] = '{0, 2'd2, 4'h9, 8'h00,  1, 0, 8'hFF,  4, 4'b1011, 1, 8'h00};
    vecs[6] = '{0, 2'd3, 4'h0, 8'h00, 15, 0, 8'h81, -1, 4'b0111, 0, 8'h81};
    vecs[7] = '{1, 2'd1, 4'hA, 8'h3C, 16, 0, 8'h00, -1, 4'b1101, 1, 8'h00};
    vecs[8] = '{0, 2'd0, 4'h6, 8'h00,  2, 0, 8'hA5,  7, 4'b1110, 1, 8'h00};
    vecs[9] = '{0, 2'd1, 4'h1, 8'h00,  0, 1, 8'h01, -1, 4'b1101, 0, 8'h01};

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_csn4", 0, 32'(o4_sci_csn), 32'(4'hF));
    check("rst_req4", 0, 32'(o4_sci_req), 32'(0));
    check("rst_rsp_valid4", 0, 32'(o4_rsp_valid), 32'(0));
    check("rst_rsp_error4", 0, 32'(o4_rsp_error), 32'(0));
    check("rst_rsp_rdata4", 0, 32'(o4_rsp_rdata), 32'(0));
    check("rst_cmd_ready4", 0, 32'(o4_cmd_ready), 32'(1));
    check("rst_csn3", 0, 32'(o3_sci_csn), 32'(3'b111));
    rstn = 1;

    for (int i = 0; i < 10; i++) run_vec(vecs[i], i);

    // Reset during the write address phase: aborts silently.
    @(negedge clk);
    c4_valid = 1; c4_write = 1; c4_pid = 2'd2; c4_addr = 4'h5; c4_wdata = 8'hA3;
    @(negedge clk);
    c4_valid = 0;
    check("mid_rst_csn_sel", 0, 32'(o4_sci_csn), 32'(4'b1011));
    @(negedge clk);
    rstn = 0;
    @(negedge clk);
    check("mid_rst_csn", 0, 32'(o4_sci_csn), 32'(4'hF));
    check("mid_rst_req", 0, 32'(o4_sci_req), 32'(0));
    check("mid_rst_ready", 0, 32'(o4_cmd_ready), 32'(1));
    rstn = 1;
    cnt = 0;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      if (o4_rsp_valid) cnt++;
    end
    check("mid_rst_no_rsp", 0, 32'(cnt), 32'(0));
    run_vec(vecs[1], 10);

    // Out-of-range pid on the 3-peripheral instance.
    @(negedge clk);
    c3_valid = 1; c3_write = 0; c3_pid = 2'd3; c3_addr = 4'h1;
    @(negedge clk);
    c3_valid = 0;
    check("badpid_csn", 0, 32'(o3_sci_csn), 32'(3'b111));
    check("badpid_valid", 0, 32'(o3_rsp_valid), 32'(1));
    check("badpid_error", 0, 32'(o3_rsp_error), 32'(1));
    check("badpid_rdata", 0, 32'(o3_rsp_rdata), 32'(0));
    check("badpid_release", 0, 32'(o3_cmd_ready), 32'(0));
    @(negedge clk);
    check("badpid_pulse_end", 0, 32'(o3_rsp_valid), 32'(0));
    check("badpid_ready", 0, 32'(o3_cmd_ready), 32'(1));

    // Highest valid pid on the 3-peripheral instance, slave always acks with 1s.
    c3_valid = 1; c3_write = 0; c3_pid = 2'd2; c3_addr = 4'h2; ack3 = 1; resp3 = 1;
    @(negedge clk);
    c3_valid = 0;
    check("pid2_csn", 0, 32'(o3_sci_csn), 32'(3'b011));
    got = 0;
    for (int n = 0; n < 40 && !got; n++) begin
      @(negedge clk);
      if (o3_rsp_valid) begin
        got = 1;
        check("pid2_error", 0, 32'(o3_rsp_error), 32'(0));
        check("pid2_rdata", 0, 32'(o3_rsp_rdata), 32'(8'hFF));
      end
    end
    check("pid2_rsp_seen", 0, 32'(got), 32'(1));
    ack3 = 0; resp3 = 0;

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 0, 32'(sb_q.size()), 32'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
